axis_uart_tx: RTL
=================

Name: axis_uart_tx

Overview:
AXI-stream byte sink that serialises each accepted byte onto an asynchronous serial line: 8N1 by default, 8N2 optional. It sits directly downstream of axis_fifo_ver0/ver1 and connects to the FIFO's odata/ovalid/oready. The FIFO absorbs bursts while this block drains them at line rate. Registered output, no combinational path from ivalid to iready.

Parameters:
BAUD_DIV, 104, clock cycles per serial bit; must be >= 2, otherwise elaboration error.
DIV_WIDTH, 8, width of the baud counter; must hold BAUD_DIV-1.
STOP_BITS, 1, number of stop bits; 1 or 2, any other value is an elaboration error.

Ports:
clock  input  1  single system clock, all logic on rising edge
resetn  input  1  asynchronous active-low reset
idata  input  8  byte to transmit
ivalid  input  1  idata valid
iready  output  1  block accepts idata this cycle
txd  output  1  serial line, idle high
busy  output  1  frame in progress

Behaviour:
- Reset (resetn low, asynchronous): state=IDLE, txd=1, busy=0, iready=0, counters=0. iready stays 0 while resetn is low and rises in the first cycle after release.
- Transfer occurs on the rising edge where ivalid && iready. idata is latched into the shift register on that edge. Upstream must hold idata stable until accepted; the block does not check this.
- iready depends only on state and counters, never on ivalid:
  - iready=1 in IDLE.
  - iready=1 in the last cycle of the last stop bit (STOP, bit counter at final stop bit, baud counter == BAUD_DIV-1).
  - iready=0 otherwise.
- States:
  - IDLE -> START on accept.
  - START -> DATA after BAUD_DIV cycles.
  - DATA -> STOP after 8*BAUD_DIV cycles.
  - STOP -> START if accept in the last stop cycle; STOP -> IDLE otherwise.
- Latency: txd goes low in the cycle after the accept edge.
- Start bit is 0. Data bits are LSB first. Stop bits are 1. Each bit lasts exactly BAUD_DIV cycles.
- Frame length: (9+STOP_BITS)*BAUD_DIV cycles. Back-to-back frames have zero idle cycles between them.
- txd is driven directly from a flop (glitch-free).
- Baud counter counts 0..BAUD_DIV-1 and wraps. It restarts at 0 on every accept.
- Bit counter counts 0..8+STOP_BITS (start=0, data=1..8, stop=9..).
- busy=1 in START/DATA/STOP, 0 in IDLE. busy stays 1 across back-to-back frames.
- Changes on idata/ivalid while not accepting have no effect on txd.
- Reset mid-frame: txd returns to 1 immediately (asynchronous). The partial frame is abandoned. The next accepted byte produces a full, correct frame.

Test Plan:
- Reset: hold resetn=0 for 3 cycles -> txd=1, busy=0, iready=0 throughout; iready=1 in the first cycle after release.
- Single byte, BAUD_DIV=4, 0xA5 accepted at cycle T -> txd=0 on T+1..T+4; data 1,0,1,0,0,1,0,1 on 4-cycle slots T+5..T+36; txd=1 on T+37..T+40; iready=1 only at T+40 inside the frame; busy=0 from T+41.
- Back-to-back, BAUD_DIV=4, 0x00 then 0xFF with ivalid held high -> second accept at T+40; its start bit on T+41..T+44 with no idle gap; line idle high from T+81; busy continuous T+1..T+80.
- Backpressure: during the 0xA5 frame drive ivalid=1 with idata toggling every cycle -> iready=0, txd waveform bit-identical to the single-byte case; the pending byte is accepted only at T+40.
- Reset mid-frame: assert resetn=0 during the data bit 3 slot -> txd=1 in the same cycle, busy=0; after release, 0x3C yields a complete 40-cycle frame with bits 0,0,1,1,1,1,0,0.
- STOP_BITS=2, BAUD_DIV=4, 0x55 -> 44-cycle frame; txd=1 on T+37..T+44; iready=1 at T+44 only.

Source files
------------

// File: rtl/axis_uart_tx.sv
// AXI-stream byte sink that serialises each accepted byte as an 8N1/8N2 asynchronous frame.
// Every output comes straight from a flop, so there is no combinational path from ivalid to iready.
module axis_uart_tx #(
    parameter int BAUD_DIV  = 104,
    parameter int DIV_WIDTH = 8,
    parameter int STOP_BITS = 1
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [7:0] idata,
    input  logic       ivalid,
    output logic       iready,
    output logic       txd,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam logic [DIV_WIDTH-1:0] BAUD_LAST = DIV_WIDTH'(BAUD_DIV - 1);
    localparam logic [DIV_WIDTH-1:0] BAUD_ONE  = DIV_WIDTH'(1);
    localparam logic [DIV_WIDTH-1:0] BAUD_ZERO = DIV_WIDTH'(0);
    localparam logic [3:0]           BIT_LAST  = 4'(8 + STOP_BITS);

    if (BAUD_DIV < 2) begin : g_bad_baud_div
        $error("axis_uart_tx: BAUD_DIV must be >= 2");
    end
    if ((longint'(BAUD_DIV) - 64'sd1) >= (64'sd1 <<< DIV_WIDTH)) begin : g_bad_div_width
        $error("axis_uart_tx: DIV_WIDTH too narrow for BAUD_DIV-1");
    end
    if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop_bits
        $error("axis_uart_tx: STOP_BITS must be 1 or 2");
    end

    state_t               state_r;
    state_t               state_nxt_s;
    logic [DIV_WIDTH-1:0] baud_cnt_r;
    logic [DIV_WIDTH-1:0] baud_nxt_s;
    logic [3:0]           bit_cnt_r;
    logic [3:0]           bit_nxt_s;
    logic [7:0]           shift_r;
    logic [7:0]           shift_nxt_s;
    logic                 iready_r;
    logic                 iready_nxt_s;
    logic                 txd_r;
    logic                 txd_nxt_s;
    logic                 busy_r;
    logic                 busy_nxt_s;
    logic                 accept_s;
    logic                 baud_end_s;

    assign accept_s   = ivalid & iready_r;
    assign baud_end_s = (baud_cnt_r == BAUD_LAST);

    // State, counters, shift register and the registered outputs.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_r    <= IDLE;
            baud_cnt_r <= BAUD_ZERO;
            bit_cnt_r  <= 4'd0;
            shift_r    <= 8'h00;
            iready_r   <= 1'b0;
            txd_r      <= 1'b1;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            baud_cnt_r <= baud_nxt_s;
            bit_cnt_r  <= bit_nxt_s;
            shift_r    <= shift_nxt_s;
            iready_r   <= iready_nxt_s;
            txd_r      <= txd_nxt_s;
            busy_r     <= busy_nxt_s;
        end
    end

    // Next-state and counter sequencing; an accept always restarts the frame timing at zero.
    always_comb begin
        state_nxt_s = state_r;
        baud_nxt_s  = baud_cnt_r;
        bit_nxt_s   = bit_cnt_r;
        shift_nxt_s = shift_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = START;
                    baud_nxt_s  = BAUD_ZERO;
                    bit_nxt_s   = 4'd0;
                    shift_nxt_s = idata;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            START: begin
                if (baud_end_s) begin
                    state_nxt_s = DATA;
                    baud_nxt_s  = BAUD_ZERO;
                    bit_nxt_s   = 4'd1;
                end else begin
                    baud_nxt_s = baud_cnt_r + BAUD_ONE;
                end
            end
            DATA: begin
                if (!baud_end_s) begin
                    baud_nxt_s = baud_cnt_r + BAUD_ONE;
                end else if (bit_cnt_r == 4'd8) begin
                    state_nxt_s = STOP;
                    baud_nxt_s  = BAUD_ZERO;
                    bit_nxt_s   = 4'd9;
                end else begin
                    baud_nxt_s  = BAUD_ZERO;
                    bit_nxt_s   = bit_cnt_r + 4'd1;
                    shift_nxt_s = {1'b0, shift_r[7:1]};
                end
            end
            STOP: begin
                if (!baud_end_s) begin
                    baud_nxt_s = baud_cnt_r + BAUD_ONE;
                end else if (bit_cnt_r != BIT_LAST) begin
                    baud_nxt_s = BAUD_ZERO;
                    bit_nxt_s  = bit_cnt_r + 4'd1;
                end else if (accept_s) begin
                    state_nxt_s = START;
                    baud_nxt_s  = BAUD_ZERO;
                    bit_nxt_s   = 4'd0;
                    shift_nxt_s = idata;
                end else begin
                    state_nxt_s = IDLE;
                    baud_nxt_s  = BAUD_ZERO;
                    bit_nxt_s   = 4'd0;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                baud_nxt_s  = BAUD_ZERO;
                bit_nxt_s   = 4'd0;
                shift_nxt_s = 8'h00;
            end
        endcase
    end

    // Output values for the coming cycle, derived from where the FSM is about to be.
    always_comb begin
        txd_nxt_s    = 1'b1;
        busy_nxt_s   = 1'b0;
        iready_nxt_s = 1'b0;
        case (state_nxt_s)
            IDLE: begin
                txd_nxt_s    = 1'b1;
                busy_nxt_s   = 1'b0;
                iready_nxt_s = 1'b1;
            end
            START: begin
                txd_nxt_s    = 1'b0;
                busy_nxt_s   = 1'b1;
                iready_nxt_s = 1'b0;
            end
            DATA: begin
                txd_nxt_s    = shift_nxt_s[0];
                busy_nxt_s   = 1'b1;
                iready_nxt_s = 1'b0;
            end
            STOP: begin
                txd_nxt_s  = 1'b1;
                busy_nxt_s = 1'b1;
                if ((bit_nxt_s == BIT_LAST) && (baud_nxt_s == BAUD_LAST)) begin
                    iready_nxt_s = 1'b1;
                end else begin
                    iready_nxt_s = 1'b0;
                end
            end
            default: begin
                txd_nxt_s    = 1'b1;
                busy_nxt_s   = 1'b0;
                iready_nxt_s = 1'b0;
            end
        endcase
    end

    assign iready = iready_r;
    assign txd    = txd_r;
    assign busy   = busy_r;

endmodule
